// File: rtl/motor_drive_sched.sv
// motor_drive_sched
//   Arbitrates drive commands from two requesters (A over B) plus an emergency stop, and
//   turns accepted commands into a safe direction/duty stream for the H-bridge PWM stage:
//   soft-start ramps, ramp-down before reversal, and dead time between directions.
//
//   Optional: define MOTOR_WATCHDOG_EN to add the inactivity watchdog (WD_CYCLES parameter,
//   wd_trip output). Without it wd_trip is tied low and RUN holds indefinitely.
//
// Ports
//   clk_100kHz        system tick clock
//   rst               synchronous active-high reset
//   estop             emergency stop level, highest priority
//   a_valid/a_dir/a_duty, a_ready   requester A command and 1-cycle accept pulse
//   b_valid/b_dir/b_duty, b_ready   requester B command and 1-cycle accept pulse
//   direction         to PWM stage: 11 fwd, 00 back, 01 halt
//   duty              current duty to PWM stage
//   busy              high whenever not IDLE
//   owner             source of last accepted command (0 = A, 1 = B)
//   wd_trip           sticky watchdog timeout flag

module motor_drive_sched #(
   parameter int unsigned MAX_DUTY    = 1000,
   parameter int unsigned RAMP_STEP   = 50,
   parameter int unsigned RAMP_DIV    = 10,
   parameter int unsigned DEAD_CYCLES = 200
`ifdef MOTOR_WATCHDOG_EN
   ,
   parameter int unsigned WD_CYCLES   = 50000
`endif
) (
   input  logic       clk_100kHz,
   input  logic       rst,
   input  logic       estop,
   input  logic       a_valid,
   input  logic [1:0] a_dir,
   input  logic [9:0] a_duty,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic [1:0] b_dir,
   input  logic [9:0] b_duty,
   output logic       b_ready,
   output logic [1:0] direction,
   output logic [9:0] duty,
   output logic       busy,
   output logic       owner,
   output logic       wd_trip
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StRamp = 3'd1;
   localparam logic [2:0] StRun  = 3'd2;
   localparam logic [2:0] StDead = 3'd3;
   localparam logic [2:0] StStop = 3'd4;

   localparam logic [1:0] DirFwd  = 2'b11;
   localparam logic [1:0] DirBack = 2'b00;
   localparam logic [1:0] DirHalt = 2'b01;

   // One counter serves as ramp divider and dead-time counter; it is cleared on state entry.
   localparam int unsigned CntMax = (RAMP_DIV > DEAD_CYCLES) ? RAMP_DIV : DEAD_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] DivLast  = CntW'(RAMP_DIV - 1);
   localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYCLES - 1);

   localparam logic [9:0]  MaxDuty10 = 10'(MAX_DUTY);
   localparam logic [10:0] Step11    = 11'(RAMP_STEP);

   logic [2:0]      state_q, state_d;
   logic [1:0]      cur_dir_q, cur_dir_d;
   logic [1:0]      tgt_dir_q, tgt_dir_d;
   logic [9:0]      tgt_duty_q, tgt_duty_d;
   logic [9:0]      duty_q, duty_d;
   logic            owner_q, owner_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic       can_accept, a_acc, b_acc, acc;
   logic [1:0] cmd_dir_raw, cmd_dir;
   logic [9:0] cmd_duty_raw, cmd_duty;
   logic       cmd_halt;
   logic       wd_fire;

   logic [10:0] duty11, tgt11, dec11, sum11;
   logic        halt_eff, ramp_down;
   logic [9:0]  ramp_next;

   // ------------------------------------------------------------------------------------------
   // Arbitration: A has fixed priority; acceptance only in IDLE/RAMP/RUN and never under estop.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      can_accept   = !rst && !estop &&
                     (state_q == StIdle || state_q == StRamp || state_q == StRun);
      a_acc        = can_accept && a_valid;
      b_acc        = can_accept && b_valid && !a_valid;
      acc          = a_acc || b_acc;
      cmd_dir_raw  = a_acc ? a_dir : b_dir;
      cmd_duty_raw = a_acc ? a_duty : b_duty;
      cmd_dir      = (cmd_dir_raw == DirFwd || cmd_dir_raw == DirBack) ? cmd_dir_raw : DirHalt;
      cmd_duty     = (cmd_duty_raw > MaxDuty10) ? MaxDuty10 : cmd_duty_raw;
      // A zero target drives state transitions exactly like a halt.
      cmd_halt     = (cmd_dir == DirHalt) || (cmd_duty == '0);
   end

   // ------------------------------------------------------------------------------------------
   // Ramp step: down toward 0 when halting or reversing, otherwise toward target, saturating.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      duty11    = {1'b0, duty_q};
      tgt11     = {1'b0, tgt_duty_q};
      halt_eff  = (tgt_dir_q == DirHalt) || (tgt_duty_q == '0);
      ramp_down = halt_eff || (tgt_dir_q != cur_dir_q);
      dec11     = (duty11 >= Step11) ? (duty11 - Step11) : '0;
      sum11     = duty11 + Step11;
      if (ramp_down) begin
         ramp_next = dec11[9:0];
      end else if (duty11 < tgt11) begin
         ramp_next = (sum11 > tgt11) ? tgt_duty_q : sum11[9:0];
      end else begin
         ramp_next = (dec11 < tgt11) ? tgt_duty_q : dec11[9:0];
      end
   end

   // ------------------------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cur_dir_d  = cur_dir_q;
      tgt_dir_d  = tgt_dir_q;
      tgt_duty_d = tgt_duty_q;
      duty_d     = duty_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;

      if (acc) begin
         tgt_dir_d  = cmd_dir;
         tgt_duty_d = cmd_duty;
         owner_d    = b_acc;
         cnt_d      = '0;
      end

      if (estop) begin
         // Hard stop: no ramp, target forgotten.
         state_d    = StStop;
         duty_d     = '0;
         tgt_dir_d  = DirHalt;
         tgt_duty_d = '0;
         cnt_d      = '0;
      end else begin
         case (state_q)
            StIdle: begin
               duty_d = '0;
               cnt_d  = '0;
               if (acc && !cmd_halt) begin
                  cur_dir_d = cmd_dir;
                  state_d   = StRamp;
               end
            end
            StRamp: begin
               // An acceptance restarts the divider, so no tick in that cycle.
               if (!acc) begin
                  if (cnt_q == DivLast) begin
                     cnt_d  = '0;
                     duty_d = ramp_next;
                     if (ramp_down) begin
                        if (ramp_next == '0) begin
                           state_d = halt_eff ? StIdle : StDead;
                        end
                     end else if (ramp_next == tgt_duty_q) begin
                        state_d = StRun;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            StRun: begin
               if (acc) begin
                  if (cmd_dir != cur_dir_q || cmd_duty != duty_q) begin
                     state_d = StRamp;
                  end
               end else if (wd_fire) begin
                  state_d = StRamp;
                  cnt_d   = '0;
               end
            end
            StDead: begin
               duty_d = '0;
               if (cnt_q == DeadLast) begin
                  cur_dir_d = tgt_dir_q;
                  state_d   = StRamp;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StStop: begin
               duty_d  = '0;
               cnt_d   = '0;
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
               duty_d  = '0;
               cnt_d   = '0;
            end
         endcase
      end

      if (wd_fire) begin
         tgt_dir_d = DirHalt;
      end
   end

   always_ff @(posedge clk_100kHz) begin
      if (rst) begin
         state_q    <= StIdle;
         cur_dir_q  <= DirHalt;
         tgt_dir_q  <= DirHalt;
         tgt_duty_q <= '0;
         duty_q     <= '0;
         owner_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         cur_dir_q  <= cur_dir_d;
         tgt_dir_q  <= tgt_dir_d;
         tgt_duty_q <= tgt_duty_d;
         duty_q     <= duty_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------------------------------
`ifdef MOTOR_WATCHDOG_EN
   localparam int unsigned WdW = $clog2(WD_CYCLES + 1);
   localparam logic [WdW-1:0] WdLast = WdW'(WD_CYCLES - 1);
   localparam logic [WdW-1:0] WdMax  = WdW'(WD_CYCLES);

   logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
   logic           wd_trip_q, wd_trip_d;

   always_comb begin
      // Counter saturates at WD_CYCLES so a timeout fires once per idle stretch.
      wd_fire = (state_q != StIdle) && (state_q != StStop) && !estop && !acc &&
                (wd_cnt_q == WdLast);
      wd_cnt_d = wd_cnt_q;
      if (acc || state_q == StIdle || state_q == StStop) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WdMax) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
      wd_trip_d = wd_trip_q;
      if (acc) begin
         wd_trip_d = 1'b0;
      end else if (wd_fire) begin
         wd_trip_d = 1'b1;
      end
   end

   always_ff @(posedge clk_100kHz) begin
      if (rst) begin
         wd_cnt_q  <= '0;
         wd_trip_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         wd_trip_q <= wd_trip_d;
      end
   end

   assign wd_trip = wd_trip_q;
`else
   assign wd_fire = 1'b0;
   assign wd_trip = 1'b0;
`endif

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   assign a_ready   = a_acc;
   assign b_ready   = b_acc;
   assign busy      = (state_q != StIdle);
   assign owner     = owner_q;
   assign duty      = duty_q;
   assign direction = (state_q == StRamp || state_q == StRun) ? cur_dir_q : DirHalt;

endmodule

// File: tb/tb_motor_drive_sched.sv
module tb_motor_drive_sched;

   logic       clk_100kHz = 1'b0;
   logic       rst = 1'b1;
   logic       estop = 1'b0;
   logic       a_valid = 1'b0;
   logic [1:0] a_dir = 2'b01;
   logic [9:0] a_duty = '0;
   logic       a_ready;
   logic       b_valid = 1'b0;
   logic [1:0] b_dir = 2'b01;
   logic [9:0] b_duty = '0;
   logic       b_ready;
   logic [1:0] direction;
   logic [9:0] duty;
   logic       busy;
   logic       owner;
   logic       wd_trip;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [1:0] dir;
      logic [9:0] duty;
      logic       busy;
   } exp_t;

   exp_t sb[$];

   always #5 clk_100kHz = ~clk_100kHz;

   motor_drive_sched #(
      .MAX_DUTY    (1000),
      .RAMP_STEP   (50),
      .RAMP_DIV    (10),
      .DEAD_CYCLES (200)
`ifdef MOTOR_WATCHDOG_EN
      ,
      .WD_CYCLES   (1000)
`endif
   ) dut (
      .clk_100kHz (clk_100kHz),
      .rst        (rst),
      .estop      (estop),
      .a_valid    (a_valid),
      .a_dir      (a_dir),
      .a_duty     (a_duty),
      .a_ready    (a_ready),
      .b_valid    (b_valid),
      .b_dir      (b_dir),
      .b_duty     (b_duty),
      .b_ready    (b_ready),
      .direction  (direction),
      .duty       (duty),
      .busy       (busy),
      .owner      (owner),
      .wd_trip    (wd_trip)
   );

   // Stimulus helpers (no checking). All start and end at posedge + 1.
   task automatic push(input int c, input logic [1:0] d, input logic [9:0] du, input logic b);
      exp_t e;
      e.cyc = c; e.dir = d; e.duty = du; e.busy = b;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk_100kHz);
      #1 rst = 1'b0;
   endtask

   // Returns just after the acceptance edge (cycle 0 of the scoreboard timeline).
   task automatic issue_a(input logic [1:0] d, input logic [9:0] du);
      a_valid = 1'b1; a_dir = d; a_duty = du;
      @(posedge clk_100kHz);
      #1 a_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_valid = 1'b1; a_dir = 2'b11; a_duty = 10'd500;
      b_valid = 1'b1; b_dir = 2'b11; b_duty = 10'd500;
      repeat (3) @(posedge clk_100kHz);
      @(negedge clk_100kHz);
      checks++;
      if ({a_ready, b_ready, busy, owner, wd_trip} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got rdyA=%b rdyB=%b busy=%b owner=%b wd=%b, want all 0",
                  a_ready, b_ready, busy, owner, wd_trip);
      end
      checks++;
      if (direction !== 2'b01 || duty !== 10'd0) begin
         errors++;
         $display("FAIL reset_out: got dir=%b duty=%0d, want dir=01 duty=0", direction, duty);
      end
      @(posedge clk_100kHz);
      #1 rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_soft_start();
      exp_t e;
      @(posedge clk_100kHz);
      #1 a_valid = 1'b1; a_dir = 2'b11; a_duty = 10'd500;
      @(negedge clk_100kHz);
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL soft_start_ready: got a_ready=%b, want 1", a_ready);
      end
      @(posedge clk_100kHz);
      #1 a_valid = 1'b0;
      push(0, 2'b11, 10'd0, 1'b1);
      push(9, 2'b11, 10'd0, 1'b1);
      push(10, 2'b11, 10'd50, 1'b1);
      push(99, 2'b11, 10'd450, 1'b1);
      push(100, 2'b11, 10'd500, 1'b1);
      push(120, 2'b11, 10'd500, 1'b1);
      for (int c = 0; c <= 120; c++) begin
         if (c != 0) begin
            @(posedge clk_100kHz);
            #1;
         end
         if (c == 1) begin
            checks++;
            if (a_ready !== 1'b0) begin
               errors++;
               $display("FAIL soft_start_pulse: got a_ready=%b, want 0", a_ready);
            end
         end
         while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (direction !== e.dir || duty !== e.duty || busy !== e.busy) begin
               errors++;
               $display("FAIL soft_start c=%0d: got dir=%b duty=%0d busy=%b, want dir=%b duty=%0d busy=%b",
                        c, direction, duty, busy, e.dir, e.duty, e.busy);
            end
         end
      end
   endtask

   task automatic test_reversal();
      exp_t e;
      issue_a(2'b00, 10'd300);
      push(0, 2'b11, 10'd500, 1'b1);
      push(10, 2'b11, 10'd450, 1'b1);
      push(99, 2'b11, 10'd50, 1'b1);
      push(100, 2'b01, 10'd0, 1'b1);
      push(299, 2'b01, 10'd0, 1'b1);
      push(300, 2'b00, 10'd0, 1'b1);
      push(310, 2'b00, 10'd50, 1'b1);
      push(359, 2'b00, 10'd250, 1'b1);
      push(360, 2'b00, 10'd300, 1'b1);
      push(380, 2'b00, 10'd300, 1'b1);
      for (int c = 0; c <= 380; c++) begin
         if (c != 0) begin
            @(posedge clk_100kHz);
            #1;
         end
         while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (direction !== e.dir || duty !== e.duty || busy !== e.busy) begin
               errors++;
               $display("FAIL reversal c=%0d: got dir=%b duty=%0d busy=%b, want dir=%b duty=%0d busy=%b",
                        c, direction, duty, busy, e.dir, e.duty, e.busy);
            end
         end
      end
   endtask

   task automatic test_arbitration();
      a_valid = 1'b1; a_dir = 2'b00; a_duty = 10'd300;
      b_valid = 1'b1; b_dir = 2'b00; b_duty = 10'd300;
      @(negedge clk_100kHz);
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL arb_both: got a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
      end
      @(posedge clk_100kHz);
      #1 a_valid = 1'b0;
      checks++;
      if (owner !== 1'b0) begin
         errors++;
         $display("FAIL arb_owner_a: got owner=%b, want 0", owner);
      end
      @(negedge clk_100kHz);
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
         errors++;
         $display("FAIL arb_b_turn: got a_ready=%b b_ready=%b, want 0 1", a_ready, b_ready);
      end
      @(posedge clk_100kHz);
      #1 b_valid = 1'b0;
      checks++;
      if (owner !== 1'b1) begin
         errors++;
         $display("FAIL arb_owner_b: got owner=%b, want 1", owner);
      end
      repeat (15) @(posedge clk_100kHz);
      #1;
      checks++;
      if (direction !== 2'b00 || duty !== 10'd300 || busy !== 1'b1) begin
         errors++;
         $display("FAIL arb_run_hold: got dir=%b duty=%0d busy=%b, want dir=00 duty=300 busy=1",
                  direction, duty, busy);
      end
   endtask

   task automatic test_clamp();
      exp_t e;
      do_reset();
      issue_a(2'b11, 10'd1023);
      push(0, 2'b11, 10'd0, 1'b1);
      push(199, 2'b11, 10'd950, 1'b1);
      push(200, 2'b11, 10'd1000, 1'b1);
      push(230, 2'b11, 10'd1000, 1'b1);
      for (int c = 0; c <= 230; c++) begin
         if (c != 0) begin
            @(posedge clk_100kHz);
            #1;
         end
         while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (direction !== e.dir || duty !== e.duty || busy !== e.busy) begin
               errors++;
               $display("FAIL clamp c=%0d: got dir=%b duty=%0d busy=%b, want dir=%b duty=%0d busy=%b",
                        c, direction, duty, busy, e.dir, e.duty, e.busy);
            end
         end
      end
   endtask

   task automatic test_small_duty_halt();
      exp_t e;
      do_reset();
      issue_a(2'b11, 10'd30);
      push(0, 2'b11, 10'd0, 1'b1);
      push(9, 2'b11, 10'd0, 1'b1);
      push(10, 2'b11, 10'd30, 1'b1);
      push(30, 2'b11, 10'd30, 1'b1);
      for (int c = 0; c <= 30; c++) begin
         if (c != 0) begin
            @(posedge clk_100kHz);
            #1;
         end
         while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (direction !== e.dir || duty !== e.duty || busy !== e.busy) begin
               errors++;
               $display("FAIL small_duty c=%0d: got dir=%b duty=%0d busy=%b, want dir=%b duty=%0d busy=%b",
                        c, direction, duty, busy, e.dir, e.duty, e.busy);
            end
         end
      end
      // Direction code 10 is a halt; ramps the 30 down in one tick and returns to IDLE.
      issue_a(2'b10, 10'd0);
      push(0, 2'b11, 10'd30, 1'b1);
      push(9, 2'b11, 10'd30, 1'b1);
      push(10, 2'b01, 10'd0, 1'b0);
      push(15, 2'b01, 10'd0, 1'b0);
      for (int c = 0; c <= 15; c++) begin
         if (c != 0) begin
            @(posedge clk_100kHz);
            #1;
         end
         while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (direction !== e.dir || duty !== e.duty || busy !== e.busy) begin
               errors++;
               $display("FAIL halt c=%0d: got dir=%b duty=%0d busy=%b, want dir=%b duty=%0d busy=%b",
                        c, direction, duty, busy, e.dir, e.duty, e.busy);
            end
         end
      end
   endtask

   task automatic test_estop();
      exp_t e;
      do_reset();
      issue_a(2'b11, 10'd500);
      push(49, 2'b11, 10'd200, 1'b1);
      push(50, 2'b11, 10'd250, 1'b1);
      for (int c = 0; c <= 50; c++) begin
         if (c != 0) begin
            @(posedge clk_100kHz);
            #1;
         end
         while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (direction !== e.dir || duty !== e.duty || busy !== e.busy) begin
               errors++;
               $display("FAIL estop_ramp c=%0d: got dir=%b duty=%0d busy=%b, want dir=%b duty=%0d busy=%b",
                        c, direction, duty, busy, e.dir, e.duty, e.busy);
            end
         end
      end
      estop = 1'b1;
      a_valid = 1'b1; a_dir = 2'b11; a_duty = 10'd500;
      b_valid = 1'b1; b_dir = 2'b00; b_duty = 10'd100;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_100kHz);
         checks++;
         if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL estop_ready i=%0d: got a_ready=%b b_ready=%b, want 0 0",
                     i, a_ready, b_ready);
         end
         @(posedge clk_100kHz);
         #1;
         checks++;
         if (direction !== 2'b01 || duty !== 10'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL estop_out i=%0d: got dir=%b duty=%0d busy=%b, want dir=01 duty=0 busy=1",
                     i, direction, duty, busy);
         end
      end
      // Release: still in STOP this cycle, so requests remain refused.
      estop = 1'b0;
      @(negedge clk_100kHz);
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL estop_release_ready: got a_ready=%b b_ready=%b, want 0 0", a_ready, b_ready);
      end
      @(posedge clk_100kHz);
      #1 a_valid = 1'b0; b_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || direction !== 2'b01 || duty !== 10'd0) begin
         errors++;
         $display("FAIL estop_idle: got busy=%b dir=%b duty=%0d, want busy=0 dir=01 duty=0",
                  busy, direction, duty);
      end
   endtask

   task automatic test_watchdog();
      exp_t e;
      int   last;
      do_reset();
      issue_a(2'b11, 10'd200);
      push(40, 2'b11, 10'd200, 1'b1);
`ifdef MOTOR_WATCHDOG_EN
      push(999, 2'b11, 10'd200, 1'b1);
      push(1000, 2'b11, 10'd200, 1'b1);
      push(1010, 2'b11, 10'd150, 1'b1);
      push(1040, 2'b01, 10'd0, 1'b0);
      last = 1040;
`else
      push(2000, 2'b11, 10'd200, 1'b1);
      last = 2000;
`endif
      for (int c = 0; c <= last; c++) begin
         if (c != 0) begin
            @(posedge clk_100kHz);
            #1;
         end
`ifdef MOTOR_WATCHDOG_EN
         if (c == 999 || c == 1000 || c == 1040) begin
            checks++;
            if (wd_trip !== (c != 999)) begin
               errors++;
               $display("FAIL wd_trip c=%0d: got %b, want %b", c, wd_trip, (c != 999));
            end
         end
`else
         if (c == 2000) begin
            checks++;
            if (wd_trip !== 1'b0) begin
               errors++;
               $display("FAIL wd_trip_off: got %b, want 0", wd_trip);
            end
         end
`endif
         while (sb.size() != 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if (direction !== e.dir || duty !== e.duty || busy !== e.busy) begin
               errors++;
               $display("FAIL watchdog c=%0d: got dir=%b duty=%0d busy=%b, want dir=%b duty=%0d busy=%b",
                        c, direction, duty, busy, e.dir, e.duty, e.busy);
            end
         end
      end
`ifdef MOTOR_WATCHDOG_EN
      issue_a(2'b11, 10'd100);
      checks++;
      if (wd_trip !== 1'b0) begin
         errors++;
         $display("FAIL wd_trip_clear: got %b, want 0", wd_trip);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_soft_start();
      test_reversal();
      test_arbitration();
      test_clamp();
      test_small_duty_halt();
      test_estop();
      test_watchdog();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish, want finish before 2 ms");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/motor_drive_sched.md
Name: motor_drive_sched

Overview:
- Arbitrates drive commands from two requesters (host link A, autonomous path B) plus an emergency stop.
- Sequences accepted commands into a safe direction/duty stream for the PWM H-bridge driver: soft-start ramps, ramp-down before reversal, and dead time between directions.
- Sits between command decoders and the motor PWM stage.
- Runs on the 100 kHz system tick clock.

Parameters:
- MAX_DUTY, 1000, duty full scale (PWM period in clocks); targets clamp to this.
- RAMP_STEP, 50, duty increment/decrement per ramp tick.
- RAMP_DIV, 10, clocks per ramp tick.
- DEAD_CYCLES, 200, halt clocks inserted on any direction reversal.
- WD_CYCLES, 50000, watchdog timeout in clocks (WATCHDOG_EN only).

Ports:
- clk_100kHz  in  1  system clock, 100 kHz.
- rst  in  1  synchronous, active-high reset.
- estop  in  1  emergency stop, level; highest priority.
- a_valid  in  1  requester A command valid.
- a_dir  in  2  A direction: 11 forward, 00 backward, 01/10 halt.
- a_duty  in  10  A target duty.
- a_ready  out  1  A command accepted (1-cycle pulse).
- b_valid  in  1  requester B command valid.
- b_dir  in  2  B direction, same encoding as a_dir.
- b_duty  in  10  B target duty.
- b_ready  out  1  B command accepted (1-cycle pulse).
- direction  out  2  to PWM stage: 11 fwd, 00 back, 01 halt.
- duty  out  10  current duty to PWM stage.
- busy  out  1  high in any state except IDLE.
- owner  out  1  source of last accepted command: 0 = A, 1 = B.
- wd_trip  out  1  sticky; set on watchdog timeout (WATCHDOG_EN only, else tied 0).

Behaviour:
- Reset (synchronous): state IDLE; direction=01, duty=0; a_ready=b_ready=0; busy=0; owner=0; wd_trip=0; target and counters cleared.
- Registered state: cur_dir, tgt_dir, tgt_duty.
- Arbitration, evaluated each cycle when not in estop:
  - A has fixed priority over B.
  - A command is accepted in IDLE, RAMP, RUN. It is never accepted in DEAD or STOP.
  - On acceptance: ready pulses high in the same cycle valid is sampled.
  - Latched values: tgt_dir ← cmd dir with 01/10 normalised to 01; tgt_duty ← min(cmd duty, MAX_DUTY); owner ← source.
  - If both valid in the same cycle: only a_ready pulses; b_valid must hold.
- Ramp tick: divider counts 0..RAMP_DIV-1 and ticks on wrap. It is cleared on each state entry and on each acceptance.
- States:
  - IDLE: direction=01, duty=0.
    - Accepted non-halt command → cur_dir←tgt_dir, go RAMP.
    - Accepted halt command → stay IDLE.
  - RAMP: direction=cur_dir. On each tick:
    - If tgt_dir≠cur_dir or tgt_dir=01: duty←max(duty−RAMP_STEP, 0).
    - Else: duty moves toward tgt_duty by RAMP_STEP, saturating exactly at tgt_duty (no overshoot).
    - duty reaches 0 with tgt_dir=01 → IDLE.
    - duty reaches 0 with tgt_dir opposite of cur_dir → DEAD.
    - duty==tgt_duty with direction matching → RUN.
  - RUN: duty held.
    - Accepted command that changes direction or duty → RAMP.
    - Identical command: accepted (ready pulses), state unchanged.
  - DEAD: direction=01, duty=0 for exactly DEAD_CYCLES clocks, then cur_dir←tgt_dir, go RAMP (ramp up from 0).
  - STOP: entered from any state in the cycle after estop is sampled high.
    - direction=01 and duty=0 immediately (no ramp); tgt cleared to halt; no acceptances.
    - Exits to IDLE the cycle after estop is sampled low.
- Target 0 with a non-halt direction behaves as halt for state transitions, but cur_dir is retained until IDLE.
- Duty arithmetic: 11-bit intermediate; no wrap below 0 or above MAX_DUTY.
- A new command mid-ramp retargets without restarting from 0 unless direction reverses.

Optional Feature:
- Macro MOTOR_WATCHDOG_EN.
- Defined:
  - Counter resets on every acceptance and in IDLE/STOP.
  - If busy and the counter reaches WD_CYCLES, force tgt_dir=01 (normal ramp-down to IDLE) and set wd_trip.
  - wd_trip clears only on rst or on the next accepted command.
- Undefined: no counter; wd_trip tied 0; RUN holds indefinitely.

Test Plan:
- Reset, then A fwd duty 500 → a_ready 1 cycle; direction=11; duty steps 50 every 10 clocks; reaches 500 after 100 clocks; state RUN; busy=1.
- In RUN fwd@500, A back duty 300 → duty ramps to 0 (100 clocks); direction=01, duty=0 for 200 clocks; then direction=00; ramps to 300 in 60 clocks.
- a_valid and b_valid same cycle → only a_ready pulses, owner=0. Next cycle with A idle → b_ready, owner=1.
- Command duty 1023 → clamps to 1000, reached after 200 clocks. Duty 30 → RUN at exactly 30 after one tick, no overshoot.
- estop pulsed mid-ramp at duty 250 → next cycle direction=01, duty=0. Requests ignored while estop high. IDLE the cycle after release.
- With MOTOR_WATCHDOG_EN, WD_CYCLES=1000, RUN@200 with no commands → at 1000 clocks wd_trip=1, ramps to 0, IDLE. Without the macro → still RUN@200 at 2000 clocks.
